// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath width, memory access size codes
// and the load/store unit state encoding.
package cpu_defs;

   localparam int XLEN = 32;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_WAIT,
      LSU_DONE,
      LSU_DISCARD
   } lsu_state_t;

endpackage

// File: rtl/mem_lsu_load_align.sv
// Load data extraction: picks byte/half/word out of the bus read data
// by address offset and sign/zero-extends it.
// Ports: data_rdata, off_q, size_q, sign_q in; load_data out.
import cpu_defs::*;

module load_align (
   input  logic [XLEN-1:0] data_rdata,
   input  logic [1:0]      off_q,
   input  logic [1:0]      size_q,
   input  logic            sign_q,
   output logic [XLEN-1:0] load_data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = data_rdata[7:0];
      unique case (off_q)
         2'd0: b = data_rdata[7:0];
         2'd1: b = data_rdata[15:8];
         2'd2: b = data_rdata[23:16];
         2'd3: b = data_rdata[31:24];
      endcase
      h = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];
      unique case (size_q)
         SZ_BYTE: load_data = {{24{sign_q & b[7]}}, b};
         SZ_HALF: load_data = {{16{sign_q & h[15]}}, h};
         default: load_data = data_rdata;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one SRAM-like bus transaction per
// load/store, aligns store data, extracts load data, stalls via lsu_ready.
// Ports: MEM control in, data_* bus out/in, adel/ades, load_result, lsu_ready.
import cpu_defs::*;

module mem_lsu (
   input  logic            clk,
   input  logic            rset,
   input  logic            mem_en,
   input  logic            mem_we,
   input  logic [1:0]      mem_size,
   input  logic            mem_sign,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   input  logic            flush,
   input  logic            pipe_advance,
   output logic            data_req,
   output logic            data_wr,
   output logic [1:0]      data_size,
   output logic [XLEN-1:0] data_addr,
   output logic [XLEN-1:0] data_wdata,
   input  logic            data_addr_ok,
   input  logic            data_data_ok,
   input  logic [XLEN-1:0] data_rdata,
   output logic            adel,
   output logic            ades,
   output logic [XLEN-1:0] load_result,
   output logic            lsu_ready
);

   lsu_state_t state_q, state_d;

   logic [1:0]      sz;
   logic            misaligned;
   logic [XLEN-1:0] wdata_al;
   logic            start;
   logic            ld_wr;
   logic            sign_q;
   logic [XLEN-1:0] ld_data;

   // Illegal size 3 behaves as a word access throughout.
   assign sz = (mem_size == 2'd3) ? SZ_WORD : mem_size;

   always_comb begin
      misaligned = 1'b0;
      wdata_al   = wdata;
      unique case (sz)
         SZ_BYTE: wdata_al = {4{wdata[7:0]}};
         SZ_HALF: begin
            misaligned = addr[0];
            wdata_al   = {2{wdata[15:0]}};
         end
         default: misaligned = |addr[1:0];
      endcase
   end

   assign adel = mem_en & ~mem_we & misaligned;
   assign ades = mem_en & mem_we & misaligned;

   assign data_req = (state_q == LSU_REQ);

   always_comb begin
      state_d   = state_q;
      lsu_ready = 1'b0;
      start     = 1'b0;
      ld_wr     = 1'b0;
      unique case (state_q)
         LSU_IDLE: begin
            start     = mem_en & ~misaligned & ~flush;
            lsu_ready = ~start;
            if (start) state_d = LSU_REQ;
         end
         LSU_REQ: begin
            // An accepted request cannot be withdrawn; its data must drain.
            if (data_addr_ok)
               state_d = flush ? LSU_DISCARD : LSU_WAIT;
            else if (flush)
               state_d = LSU_IDLE;
         end
         LSU_WAIT: begin
            if (data_data_ok) begin
               if (flush) state_d = LSU_IDLE;
               else begin
                  state_d = LSU_DONE;
                  ld_wr   = ~data_wr;
               end
            end else if (flush) begin
               state_d = LSU_DISCARD;
            end
         end
         LSU_DONE: begin
            lsu_ready = 1'b1;
            if (flush | pipe_advance) state_d = LSU_IDLE;
         end
         LSU_DISCARD: begin
            if (data_data_ok) state_d = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   load_align u_align (
      .data_rdata (data_rdata),
      .off_q      (data_addr[1:0]),
      .size_q     (data_size),
      .sign_q     (sign_q),
      .load_data  (ld_data)
   );

   always_ff @(posedge clk) begin
      if (!rset) begin
         state_q     <= LSU_IDLE;
         data_wr     <= 1'b0;
         data_size   <= 2'd0;
         data_addr   <= '0;
         data_wdata  <= '0;
         sign_q      <= 1'b0;
         load_result <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            data_wr    <= mem_we;
            data_size  <= sz;
            data_addr  <= addr;
            data_wdata <= wdata_al;
            sign_q     <= mem_sign;
         end
         if (ld_wr) load_result <= ld_data;
      end
   end

endmodule
